// File: rtl/instr_fetch_decode.sv
// Front-end fetch/decode stage: fetches 16-bit instructions, resolves JMP and HALT
// locally, and hands all other decoded instructions downstream over valid/ready.
module instr_fetch_decode #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned AW      = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         opcode,
  output logic [2:0]         write_address_reg,
  output logic [2:0]         reg1,
  output logic [2:0]         reg2,
  output logic [DATA_W-1:0]  data_in,
  output logic [AW-1:0]      pc_out,
  output logic               halted,
  output logic [CNT_W-1:0]   issued_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;

  state_e             state_q;
  logic [AW-1:0]      pc_q;
  logic               imem_req_q;
  logic [AW-1:0]      imem_addr_q;
  logic               out_valid_q;
  logic [3:0]         opcode_q;
  logic [2:0]         wr_addr_q;
  logic [2:0]         reg1_q;
  logic [2:0]         reg2_q;
  logic [DATA_W-1:0]  data_in_q;
  logic [AW-1:0]      pc_out_q;
  logic               halted_q;
  logic [CNT_W-1:0]   issued_count_q;

  logic [3:0]         rd_op;
  logic [AW-1:0]      jmp_tgt;

  assign rd_op   = imem_rdata[15:12];
  assign jmp_tgt = imem_rdata[AW-1:0];

  // Control FSM; every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= '0;
      out_valid_q    <= 1'b0;
      opcode_q       <= '0;
      wr_addr_q      <= '0;
      reg1_q         <= '0;
      reg2_q         <= '0;
      data_in_q      <= '0;
      pc_out_q       <= '0;
      halted_q       <= 1'b0;
      issued_count_q <= '0;
    end else begin
      imem_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q        <= '0;
            imem_addr_q <= '0;
            imem_req_q  <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (rd_op == OP_HALT) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else if (rd_op == OP_JMP) begin
              pc_q        <= jmp_tgt;
              imem_addr_q <= jmp_tgt;
              imem_req_q  <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              opcode_q    <= rd_op;
              wr_addr_q   <= imem_rdata[11:9];
              reg1_q      <= imem_rdata[8:6];
              reg2_q      <= imem_rdata[5:3];
              data_in_q   <= DATA_W'(imem_rdata[5:0]);
              pc_out_q    <= pc_q;
              pc_q        <= pc_q + AW'(1);
              out_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Fetch of the next instruction starts on the handshake edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (issued_count_q != '1) begin
              issued_count_q <= issued_count_q + CNT_W'(1);
            end
            imem_addr_q <= pc_q;
            imem_req_q  <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            halted_q    <= 1'b0;
            pc_q        <= '0;
            imem_addr_q <= '0;
            imem_req_q  <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req          = imem_req_q;
  assign imem_addr         = imem_addr_q;
  assign out_valid         = out_valid_q;
  assign opcode            = opcode_q;
  assign write_address_reg = wr_addr_q;
  assign reg1              = reg1_q;
  assign reg2              = reg2_q;
  assign data_in           = data_in_q;
  assign pc_out            = pc_out_q;
  assign halted            = halted_q;
  assign issued_count      = issued_count_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a small instruction-memory responder.
module tb_instr_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [2:0]  write_address_reg;
  logic [2:0]  reg1;
  logic [2:0]  reg2;
  logic [7:0]  data_in;
  logic [7:0]  pc_out;
  logic        halted;
  logic [15:0] issued_count;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] mem [256];
  logic        mem_en;
  logic        pend;
  logic [15:0] pend_data;
  logic [7:0]  fetch_q [$];

  instr_fetch_decode dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .imem_rvalid       (imem_rvalid),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .opcode            (opcode),
    .write_address_reg (write_address_reg),
    .reg1              (reg1),
    .reg2              (reg2),
    .data_in           (data_in),
    .pc_out            (pc_out),
    .halted            (halted),
    .issued_count      (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one full cycle after it sees a request.
  always @(negedge clk) begin
    if (mem_en) begin
      imem_rvalid = pend;
      imem_rdata  = pend_data;
      pend        = imem_req;
      pend_data   = mem[imem_addr];
    end
    if (imem_req) fetch_q.push_back(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("wait_valid_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_halt();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1'b1; break; end
    end
    chk("wait_halt_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    mem_en = 1'b1; pend = 1'b0; pend_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req",  32'(imem_req), 32'd0);
    chk("rst_halted",    32'(halted), 32'd0);
    chk("rst_count",     32'(issued_count), 32'd0);
    chk("rst_opcode",    32'(opcode), 32'd0);
    chk("rst_data_in",   32'(data_in), 32'd0);
    rst_n = 1'b1;

    // Basic issue of 0x1234 then HALT
    mem[0] = 16'h1234; mem[1] = 16'h0000;
    out_ready = 1'b1;
    pulse_start();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'h00);
    wait_valid();
    chk("t1_opcode", 32'(opcode), 32'h1);
    chk("t1_wa",     32'(write_address_reg), 32'd1);
    chk("t1_reg1",   32'(reg1), 32'd0);
    chk("t1_reg2",   32'(reg2), 32'd6);
    chk("t1_data",   32'(data_in), 32'h34);
    chk("t1_pc_out", 32'(pc_out), 32'h00);
    @(negedge clk);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_count",      32'(issued_count), 32'd1);
    chk("t1_next_req",   32'(imem_req), 32'd1);
    chk("t1_next_addr",  32'(imem_addr), 32'h01);
    wait_halt();
    chk("t1_halt_count", 32'(issued_count), 32'd1);
    chk("t1_halt_valid", 32'(out_valid), 32'd0);

    // Restart from HALT with back-pressure on 0x5ABC
    mem[0] = 16'h5ABC; mem[1] = 16'h0000;
    out_ready = 1'b0;
    pulse_start();
    chk("t2_halt_clr", 32'(halted), 32'd0);
    chk("t2_req",      32'(imem_req), 32'd1);
    chk("t2_addr",     32'(imem_addr), 32'h00);
    chk("t2_count_kept", 32'(issued_count), 32'd1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t2_bp_valid",  32'(out_valid), 32'd1);
      chk("t2_bp_req",    32'(imem_req), 32'd0);
      chk("t2_bp_opcode", 32'(opcode), 32'h5);
      chk("t2_bp_wa",     32'(write_address_reg), 32'd5);
      chk("t2_bp_reg1",   32'(reg1), 32'd2);
      chk("t2_bp_reg2",   32'(reg2), 32'd7);
      chk("t2_bp_data",   32'(data_in), 32'h3C);
      chk("t2_bp_count",  32'(issued_count), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drop", 32'(out_valid), 32'd0);
    chk("t2_count",      32'(issued_count), 32'd2);
    @(negedge clk);
    chk("t2_single_acc", 32'(issued_count), 32'd2);
    wait_halt();

    // JMP program: issue at 0, JMP at 1 to 5, HALT at 5
    mem[0] = 16'h2041; mem[1] = 16'hE005; mem[5] = 16'h0000;
    fetch_q.delete();
    pulse_start();
    wait_valid();
    chk("t3_opcode", 32'(opcode), 32'h2);
    chk("t3_pc_out", 32'(pc_out), 32'h00);
    chk("t3_data",   32'(data_in), 32'h01);
    wait_halt();
    chk("t3_nfetch", 32'(fetch_q.size()), 32'd3);
    if (fetch_q.size() == 3) begin
      chk("t3_fetch0", 32'(fetch_q[0]), 32'h00);
      chk("t3_fetch1", 32'(fetch_q[1]), 32'h01);
      chk("t3_fetch2", 32'(fetch_q[2]), 32'h05);
    end
    chk("t3_count", 32'(issued_count), 32'd3);

    // PC wrap at 0xFF
    mem[0] = 16'hE0FF; mem[255] = 16'h3000;
    pulse_start();
    wait_valid();
    chk("t4_opcode", 32'(opcode), 32'h3);
    chk("t4_pc_out", 32'(pc_out), 32'hFF);
    mem[0] = 16'h0000;
    @(negedge clk);
    chk("t4_wrap_req",  32'(imem_req), 32'd1);
    chk("t4_wrap_addr", 32'(imem_addr), 32'h00);
    wait_halt();
    chk("t4_count", 32'(issued_count), 32'd4);

    // Async reset during ISSUE, then a stray response in IDLE
    mem[0] = 16'h1234;
    out_ready = 1'b0;
    pulse_start();
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",  32'(out_valid), 32'd0);
    chk("t5_rst_halted", 32'(halted), 32'd0);
    chk("t5_rst_count",  32'(issued_count), 32'd0);
    chk("t5_rst_opcode", 32'(opcode), 32'd0);
    mem_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 16'h4123;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_idle_valid", 32'(out_valid), 32'd0);
      chk("t5_idle_req",   32'(imem_req), 32'd0);
      chk("t5_idle_op",    32'(opcode), 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
